// File: rtl/pipeline_hazard_controller.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_controller
//   Hazard control for the 5-stage core. Produces the stall / flush / enable
//   signals that gate the inter-stage pipeline registers and the execute-stage
//   forwarding selects. Handles load-use stalls, taken branch/jump flushes,
//   data-memory wait freezes and a one-cycle boot flush after reset that
//   scrubs pipeline registers which have no reset of their own.
//   Saturating event counters are kept for performance debug.
//
// Parameters
//   CNT_W     width of each saturating event counter
//   MAX_WAIT  memory wait cycles before MemTimeout is raised
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   Rs1D, Rs2D              source registers of the Decode instruction
//   Rs1E, Rs2E, RdE         source/destination registers in Execute
//   ResultSrcE              2'b01 marks a load in Execute
//   PCSrcE                  taken branch/jump resolved in Execute
//   RegWriteM/RdM           Memory-stage writeback info
//   RegWriteW/RdW           Writeback-stage writeback info
//   MemReqM, MemReadyM      data memory request / completion
//   StallF, StallD          hold PC / F->D register
//   FlushD, FlushE          bubble F->D / D->E register
//   EnE, EnM, EnW           enables for D->E, E->M, M->W registers
//   ForwardAE, ForwardBE    00 regfile, 01 ResultW, 10 ALUResultM
//   MemTimeout              sticky memory-wait timeout flag
//   LwStallCnt, MemWaitCnt, FlushCnt   saturating event counters
// -----------------------------------------------------------------------------
module pipeline_hazard_controller #(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic             RegWriteM,
    input  logic [4:0]       RdM,
    input  logic             RegWriteW,
    input  logic [4:0]       RdW,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic             EnE,
    output logic             EnM,
    output logic             EnW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] LwStallCnt,
    output logic [CNT_W-1:0] MemWaitCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0]  CNT_SAT  = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    // Forward select for one execute operand; M has priority over W (younger result).
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic       reg_write_m,
                                           input logic [4:0] rd_m,
                                           input logic       reg_write_w,
                                           input logic [4:0] rd_w);
        logic [1:0] sel;
        if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = 2'b10;
        end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                 input logic             ev);
        logic [CNT_W-1:0] nxt;
        if (ev && (cnt != CNT_SAT)) begin
            nxt = cnt + CNT_W'(1);
        end else begin
            nxt = cnt;
        end
        return nxt;
    endfunction

    state_t            state_r, state_s;
    logic [WAIT_W-1:0] wait_cnt_r, wait_cnt_s;
    logic              boot_r;
    logic              mem_timeout_r, mem_timeout_s;
    logic [CNT_W-1:0]  lw_cnt_r, mw_cnt_r, fl_cnt_r;

    logic freeze_s, lw_stall_s;
    logic stall_f_s, stall_d_s, flush_d_s, flush_e_s, en_s;
    logic ev_lw_s, ev_wait_s, ev_flush_s;

    assign freeze_s   = MemReqM & ~MemReadyM;
    assign lw_stall_s = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                        ((RdE == Rs1D) || (RdE == Rs2D));

    // Prioritised stall/flush/enable decode; boot (also asserted during reset) overrides all.
    always_comb begin
        stall_f_s  = 1'b0;
        stall_d_s  = 1'b0;
        flush_d_s  = 1'b0;
        flush_e_s  = 1'b0;
        en_s       = 1'b1;
        ev_lw_s    = 1'b0;
        ev_wait_s  = 1'b0;
        ev_flush_s = 1'b0;
        if (boot_r) begin
            flush_d_s = 1'b1;
            flush_e_s = 1'b1;
        end else if (freeze_s) begin
            // Whole pipe holds; a pending branch or load-use is replayed after release.
            stall_f_s = 1'b1;
            stall_d_s = 1'b1;
            en_s      = 1'b0;
            ev_wait_s = 1'b1;
        end else if (PCSrcE) begin
            // Decode instruction is discarded, so any load-use on it is irrelevant.
            flush_d_s  = 1'b1;
            flush_e_s  = 1'b1;
            ev_flush_s = 1'b1;
        end else if (lw_stall_s) begin
            stall_f_s = 1'b1;
            stall_d_s = 1'b1;
            flush_e_s = 1'b1;
            ev_lw_s   = 1'b1;
        end else begin
            en_s = 1'b1;
        end
    end

    // Memory-wait FSM next state, wait counter and sticky timeout.
    always_comb begin
        state_s       = state_r;
        wait_cnt_s    = wait_cnt_r;
        mem_timeout_s = mem_timeout_r;
        case (state_r)
            ST_RUN: begin
                if (freeze_s) begin
                    state_s    = ST_MEM_WAIT;
                    wait_cnt_s = WAIT_W'(1);
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (wait_cnt_r == WAIT_MAX) begin
                    mem_timeout_s = 1'b1;
                end else begin
                    mem_timeout_s = mem_timeout_r;
                end
                if (MemReadyM) begin
                    state_s = ST_RUN;
                end else if (wait_cnt_r != WAIT_MAX) begin
                    wait_cnt_s = wait_cnt_r + WAIT_W'(1);
                end else begin
                    wait_cnt_s = wait_cnt_r;
                end
            end
            default: begin
                state_s    = ST_RUN;
                wait_cnt_s = '0;
            end
        endcase
    end

    // State, boot flag, timeout and event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_RUN;
            wait_cnt_r    <= '0;
            boot_r        <= 1'b1;
            mem_timeout_r <= 1'b0;
            lw_cnt_r      <= '0;
            mw_cnt_r      <= '0;
            fl_cnt_r      <= '0;
        end else begin
            state_r       <= state_s;
            wait_cnt_r    <= wait_cnt_s;
            boot_r        <= 1'b0;
            mem_timeout_r <= mem_timeout_s;
            lw_cnt_r      <= sat_inc(lw_cnt_r, ev_lw_s);
            mw_cnt_r      <= sat_inc(mw_cnt_r, ev_wait_s);
            fl_cnt_r      <= sat_inc(fl_cnt_r, ev_flush_s);
        end
    end

    assign StallF     = stall_f_s;
    assign StallD     = stall_d_s;
    assign FlushD     = flush_d_s;
    assign FlushE     = flush_e_s;
    assign EnE        = en_s;
    assign EnM        = en_s;
    assign EnW        = en_s;
    assign ForwardAE  = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
    assign ForwardBE  = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
    assign MemTimeout = mem_timeout_r;
    assign LwStallCnt = lw_cnt_r;
    assign MemWaitCnt = mw_cnt_r;
    assign FlushCnt   = fl_cnt_r;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
module tb_pipeline_hazard_controller;

    localparam int CNT_W    = 4;
    localparam int MAX_WAIT = 6;
    localparam int SAT      = 15;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0] ResultSrcE;
    logic PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
    logic StallF, StallD, FlushD, FlushE, EnE, EnM, EnW, MemTimeout;
    logic [1:0] ForwardAE, ForwardBE;
    logic [CNT_W-1:0] LwStallCnt, MemWaitCnt, FlushCnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_boot;
    bit m_in_wait;
    int m_wait_len;
    bit m_timeout;
    int m_lw, m_mw, m_fl;

    always #5 clk = ~clk;

    pipeline_hazard_controller #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .RegWriteM(RegWriteM), .RdM(RdM), .RegWriteW(RegWriteW), .RdW(RdW),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .EnE(EnE), .EnM(EnM), .EnW(EnW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MemTimeout(MemTimeout),
        .LwStallCnt(LwStallCnt), .MemWaitCnt(MemWaitCnt), .FlushCnt(FlushCnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
        if (RegWriteM && RdM != 5'd0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 5'd0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    // Compare every DUT output against the model for the current cycle.
    task automatic compare_all();
        bit frz, lw;
        logic [4:0] e;  // {StallF, StallD, FlushD, FlushE, En}
        frz = MemReqM && !MemReadyM;
        lw  = (ResultSrcE == 2'b01) && (RdE != 5'd0) && (RdE == Rs1D || RdE == Rs2D);
        if (m_boot)        e = 5'b00111;
        else if (frz)      e = 5'b11000;
        else if (PCSrcE)   e = 5'b00111;
        else if (lw)       e = 5'b11011;
        else               e = 5'b00001;
        check("StallF", 32'(StallF), 32'(e[4]));
        check("StallD", 32'(StallD), 32'(e[3]));
        check("FlushD", 32'(FlushD), 32'(e[2]));
        check("FlushE", 32'(FlushE), 32'(e[1]));
        check("EnE",    32'(EnE),    32'(e[0]));
        check("EnM",    32'(EnM),    32'(e[0]));
        check("EnW",    32'(EnW),    32'(e[0]));
        check("ForwardAE", 32'(ForwardAE), 32'(exp_fwd(Rs1E)));
        check("ForwardBE", 32'(ForwardBE), 32'(exp_fwd(Rs2E)));
        check("MemTimeout", 32'(MemTimeout), 32'(m_timeout));
        check("LwStallCnt", 32'(LwStallCnt), 32'(m_lw));
        check("MemWaitCnt", 32'(MemWaitCnt), 32'(m_mw));
        check("FlushCnt",   32'(FlushCnt),   32'(m_fl));
    endtask

    // Advance the model across one rising edge using the current inputs.
    task automatic model_edge();
        bit frz, lw;
        frz = MemReqM && !MemReadyM;
        lw  = (ResultSrcE == 2'b01) && (RdE != 5'd0) && (RdE == Rs1D || RdE == Rs2D);
        if (!m_boot) begin
            if (frz)         begin if (m_mw < SAT) m_mw++; end
            else if (PCSrcE) begin if (m_fl < SAT) m_fl++; end
            else if (lw)     begin if (m_lw < SAT) m_lw++; end
        end
        if (!m_in_wait) begin
            if (frz) begin
                m_in_wait  = 1'b1;
                m_wait_len = 1;
            end
        end else begin
            if (m_wait_len >= MAX_WAIT) m_timeout = 1'b1;
            if (MemReadyM) m_in_wait = 1'b0;
            else           m_wait_len++;
        end
        m_boot = 1'b0;
    endtask

    task automatic clear_inputs();
        Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0; RdE = 5'd0;
        RdM = 5'd0; RdW = 5'd0; ResultSrcE = 2'b00; PCSrcE = 1'b0;
        RegWriteM = 1'b0; RegWriteW = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b1;
    endtask

    // Called at posedge+1 with inputs already applied.
    task automatic step();
        #2;
        compare_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Called at posedge+1; asserts reset asynchronously, releases at a later posedge+1.
    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        m_boot = 1'b1; m_in_wait = 1'b0; m_wait_len = 0; m_timeout = 1'b0;
        m_lw = 0; m_mw = 0; m_fl = 0;
        #2;
        compare_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int burst;

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Reset release: one boot-flush cycle, then quiet.
        check("boot_flushd_lit", 32'(FlushD), 32'd1);
        step();
        check("post_boot_flushd_lit", 32'(FlushD), 32'd0);
        check("post_boot_fwd_lit", 32'(ForwardAE), 32'd0);
        step();

        // Load-use stall, then RdE=0 must not stall.
        ResultSrcE = 2'b01; RdE = 5'd5; Rs1D = 5'd5;
        #2 check("lw_stallf_lit", 32'(StallF), 32'd1);
        #0;
        step_after_lit();
        ResultSrcE = 2'b00; RdE = 5'd0; Rs1D = 5'd0;
        check("lw_cnt_lit", 32'(LwStallCnt), 32'd1);
        ResultSrcE = 2'b01; Rs1D = 5'd0;
        step();

        // Branch beats load-use.
        RdE = 5'd5; Rs1D = 5'd5; PCSrcE = 1'b1;
        step();
        clear_inputs();
        check("flush_cnt_lit", 32'(FlushCnt), 32'd1);
        check("lw_cnt_keep_lit", 32'(LwStallCnt), 32'd1);

        // Three-cycle memory freeze with a pending branch, then release.
        MemReqM = 1'b1; MemReadyM = 1'b0; PCSrcE = 1'b1;
        repeat (3) step();
        MemReadyM = 1'b1;
        step();
        clear_inputs();
        check("mem_wait_cnt_lit", 32'(MemWaitCnt), 32'd3);
        check("flush_after_wait_lit", 32'(FlushCnt), 32'd2);

        // Forwarding priorities and x0.
        RdM = 5'd7; RdW = 5'd7; RegWriteM = 1'b1; RegWriteW = 1'b1; Rs1E = 5'd7;
        #2 check("fwd_m_lit", 32'(ForwardAE), 32'd2);
        RegWriteM = 1'b0;
        #1 check("fwd_w_lit", 32'(ForwardAE), 32'd1);
        RegWriteM = 1'b1; RdM = 5'd0; Rs2E = 5'd0;
        #1 check("fwd_x0_lit", 32'(ForwardBE), 32'd0);
        @(posedge clk); model_edge(); #1;
        clear_inputs();

        // Timeout: hold not-ready beyond MAX_WAIT, stays set after release.
        MemReqM = 1'b1; MemReadyM = 1'b0;
        repeat (MAX_WAIT + 2) step();
        MemReadyM = 1'b1;
        step();
        clear_inputs();
        step();
        check("timeout_sticky_lit", 32'(MemTimeout), 32'd1);
        MemReqM = 1'b1; MemReadyM = 1'b0;
        repeat (2) step();
        do_reset();
        check("timeout_cleared_lit", 32'(MemTimeout), 32'd0);
        step();

        // Randomized traffic against the model.
        burst = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                do_reset();
                step();   // boot cycle with quiet inputs
            end
            Rs1D = 5'($urandom_range(0, 7)); Rs2D = 5'($urandom_range(0, 7));
            Rs1E = 5'($urandom_range(0, 7)); Rs2E = 5'($urandom_range(0, 7));
            RdE  = 5'($urandom_range(0, 7)); RdM  = 5'($urandom_range(0, 7));
            RdW  = 5'($urandom_range(0, 7));
            ResultSrcE = 2'($urandom_range(0, 3));
            PCSrcE    = ($urandom_range(0, 5) == 0);
            RegWriteM = $urandom_range(0, 1) == 1;
            RegWriteW = $urandom_range(0, 1) == 1;
            MemReqM   = ($urandom_range(0, 2) == 0);
            if (burst > 0) begin
                MemReadyM = 1'b0;
                burst--;
            end else begin
                MemReadyM = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 39) == 0) burst = 10;
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Finishes the load-use cycle whose literal was checked mid-cycle.
    task automatic step_after_lit();
        compare_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

endmodule
